// File: rtl/fixed_point_subtract_pkg.sv
// Shared types and elaboration helpers for the digit-serial subtractor.
package fixed_point_subtract_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Digit counter width; a single-digit datapath still gets a 1-bit counter.
    function automatic int cnt_width(input int n, input int k);
        int digits;
        if (k < 1) return 1;
        digits = n / k;
        return (digits <= 1) ? 1 : $clog2(digits);
    endfunction

endpackage

// File: rtl/subtract_digit.sv
// One K-bit digit of a - b computed as a + ~b + cin.
module subtract_digit #(
    parameter int K = 8
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         cin,
    output logic [K-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, ~b} + {{K{1'b0}}, cin};

endmodule

// File: rtl/digit_serial_subtract.sv
// Multi-cycle N-bit subtractor, K bits per clock, with a registered borrow chain
// and valid/ready handshakes on operands and result.
module digit_serial_subtract
    import fixed_point_subtract_pkg::*;
#(
    parameter int N = 32,
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         bo,
    output logic         v
);

    localparam int D  = N / K;
    localparam int CW = cnt_width(N, K);
    localparam logic [CW-1:0] LAST = CW'(D - 1);

    if ((K < 1) ? 1'b1 : ((N % K) != 0)) begin : g_bad_params
        $error("digit_serial_subtract: K must be >= 1 and divide N");
    end

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_carry;
    logic [D-1:0][K-1:0]   r_a;
    logic [D-1:0][K-1:0]   r_b;
    logic [D-1:0][K-1:0]   r_d;
    logic                  r_bo;
    logic                  r_v;

    logic [K-1:0]          w_a_dig;
    logic [K-1:0]          w_b_dig;
    logic [K-1:0]          w_sum;
    logic                  w_cout;
    logic                  w_accept;

    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign d         = r_d;
    assign bo        = r_bo;
    assign v         = r_v;

    // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
    always_comb begin
        w_a_dig = '0;
        w_b_dig = '0;
        for (int i = 0; i < D; i++) begin
            if (r_cnt == CW'(i)) begin
                w_a_dig = r_a[i];
                w_b_dig = r_b[i];
            end
        end
    end

    subtract_digit #(.K(K)) u_digit (
        .a    (w_a_dig),
        .b    (w_b_dig),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // NOTE: the operand copies carry no reset; they are always loaded on acceptance before use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= a;
            r_b <= b;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_d     <= '0;
            r_bo    <= 1'b0;
            r_v     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_carry <= ~bi;
                        r_cnt   <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    for (int i = 0; i < D; i++) begin
                        if (r_cnt == CW'(i)) r_d[i] <= w_sum;
                    end
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        // The top digit's sum MSB is the new d[N-1].
                        r_bo    <= ~w_cout;
                        r_v     <= (r_a[D-1][K-1] ^ r_b[D-1][K-1]) &
                                   (r_a[D-1][K-1] ^ w_sum[K-1]);
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_subtract.sv
// Self-checking bench: three instances (K=8, K=32, K=1) against an arithmetic reference.
module tb_digit_serial_subtract;

    localparam int NI = 3;

    logic        clk;
    logic        rst;
    logic        iv    [NI];
    logic        ir    [NI];
    logic [31:0] a_s   [NI];
    logic [31:0] b_s   [NI];
    logic        bi_s  [NI];
    logic        ov    [NI];
    logic        ord   [NI];
    logic [31:0] d_s   [NI];
    logic        bo_s  [NI];
    logic        v_s   [NI];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bi;
        logic [31:0] d;
        logic        bo;
        logic        v;
    } vec_t;

    vec_t vecs [6];

    digit_serial_subtract #(.N(32), .K(8)) u_dut_k8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_s[0]), .b(b_s[0]), .bi(bi_s[0]), .out_valid(ov[0]),
        .out_ready(ord[0]), .d(d_s[0]), .bo(bo_s[0]), .v(v_s[0])
    );

    digit_serial_subtract #(.N(32), .K(32)) u_dut_k32 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_s[1]), .b(b_s[1]), .bi(bi_s[1]), .out_valid(ov[1]),
        .out_ready(ord[1]), .d(d_s[1]), .bo(bo_s[1]), .v(v_s[1])
    );

    digit_serial_subtract #(.N(32), .K(1)) u_dut_k1 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_s[2]), .b(b_s[2]), .bi(bi_s[2]), .out_valid(ov[2]),
        .out_ready(ord[2]), .d(d_s[2]), .bo(bo_s[2]), .v(v_s[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int digits(input int idx);
        case (idx)
            0:       return 4;
            1:       return 1;
            default: return 32;
        endcase
    endfunction

    // Reference: plain integer arithmetic, {bo, v, d}.
    function automatic logic [33:0] ref_sub(input logic [31:0] av, input logic [31:0] bv,
                                            input logic biv);
        longint ua, ub, sa, sb, ud, sd;
        logic   r_bo, r_v;
        ua = longint'(av);
        ub = longint'(bv);
        sa = $signed(av);
        sb = $signed(bv);
        ud = ua - ub - longint'(biv);
        sd = sa - sb - longint'(biv);
        r_bo = (ud < 0);
        r_v  = (sd < -64'sd2147483648) || (sd > 64'sd2147483647);
        return {r_bo, r_v, ud[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_result(input int idx, output int lat);
        lat = 0;
        while (!ov[idx] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic start_op(input int idx, input logic [31:0] av, input logic [31:0] bv,
                            input logic biv, output int lat);
        int w;
        @(negedge clk);
        iv[idx]   = 1'b1;
        a_s[idx]  = av;
        b_s[idx]  = bv;
        bi_s[idx] = biv;
        w = 0;
        while (!ir[idx] && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        iv[idx]   = 1'b0;
        a_s[idx]  = $urandom;
        b_s[idx]  = $urandom;
        bi_s[idx] = ~biv;
        wait_result(idx, lat);
    endtask

    task automatic release_result(input int idx);
        ord[idx] = 1'b1;
        @(negedge clk);
        ord[idx] = 1'b0;
    endtask

    task automatic run_and_check(input int idx, input string tag, input logic [31:0] av,
                                 input logic [31:0] bv, input logic biv,
                                 input logic [33:0] exp);
        int lat;
        start_op(idx, av, bv, biv, lat);
        check({tag, " latency"}, 64'(lat), 64'(digits(idx)));
        check({tag, " d"},  64'(d_s[idx]),  64'(exp[31:0]));
        check({tag, " bo"}, 64'(bo_s[idx]), 64'(exp[33]));
        check({tag, " v"},  64'(v_s[idx]),  64'(exp[32]));
        release_result(idx);
    endtask

    initial begin
        int lat;
        logic [31:0] ra, rb;
        logic        rbi;

        for (int i = 0; i < NI; i++) begin
            iv[i] = 1'b0; ord[i] = 1'b0; a_s[i] = '0; b_s[i] = '0; bi_s[i] = 1'b0;
        end
        rst = 1'b1;
        #12;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset[%0d] state", i),
                  {59'd0, ir[i], ov[i], bo_s[i], v_s[i], 1'b0}, {59'd0, 5'b10000});
            check($sformatf("reset[%0d] d", i), 64'(d_s[i]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFE, 1'b0, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
        vecs[5] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            run_and_check(0, $sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bi,
                          {vecs[i].bo, vecs[i].v, vecs[i].d});
        end

        // Backpressure: result held for 10 cycles, in_valid pulse ignored.
        start_op(0, 32'h5, 32'h3, 1'b0, lat);
        check("bp latency", 64'(lat), 64'd4);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                iv[0] = 1'b1; a_s[0] = 32'hAAAA_AAAA; b_s[0] = 32'h5555_5555;
            end else begin
                iv[0] = 1'b0;
            end
            @(negedge clk);
            check($sformatf("bp hold %0d", c),
                  {27'd0, ov[0], ir[0], bo_s[0], v_s[0], d_s[0]},
                  {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2});
        end
        // Release with in_valid already high: the release edge must not accept it.
        iv[0] = 1'b1; a_s[0] = 32'h20; b_s[0] = 32'h1; bi_s[0] = 1'b0;
        ord[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp release", {62'd0, ir[0], ov[0]}, 64'b10);
        @(negedge clk);
        ord[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        wait_result(0, lat);
        check("post-release latency", 64'(lat), 64'd4);
        check("post-release d", 64'(d_s[0]), 64'h1F);
        release_result(0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        iv[0] = 1'b1; a_s[0] = 32'hFFFF_FFFF; b_s[0] = 32'h1234_5678; bi_s[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst state", {59'd0, ir[0], ov[0], bo_s[0], v_s[0], 1'b0}, {59'd0, 5'b10000});
        check("midrst d", 64'(d_s[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_and_check(0, "after-rst", 32'h10, 32'h01, 1'b0, ref_sub(32'h10, 32'h01, 1'b0));

        // Randomized ops on each instance.
        for (int idx = 0; idx < NI; idx++) begin
            int n_ops;
            n_ops = (idx == 0) ? 1000 : 300;
            for (int k = 0; k < n_ops; k++) begin
                ra  = $urandom;
                rb  = $urandom;
                rbi = 1'($urandom_range(0, 1));
                run_and_check(idx, $sformatf("rnd%0d.%0d", idx, k), ra, rb, rbi,
                              ref_sub(ra, rb, rbi));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/digit_serial_subtract.md
Name: digit_serial_subtract

Overview:
- Multi-cycle fixed-point subtractor for the FixedPointArithmetic IP; the inverse-operation counterpart of the adder units.
- Computes d = a - b - bi over N bits, K bits per clock, as a + ~b + ~bi.
- A borrow chain is registered between digits. The block trades latency for a short critical path.
- Sits behind a valid/ready operand interface and presents a registered result with a valid/ready handshake.

Parameters:
- N, 32, datapath width in bits.
- K, 8, digit width processed per clock. N % K == 0 and K >= 1 are required. Elaboration fails otherwise.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b, bi are valid.
- in_ready  output  1  block can accept operands.
- a  input  N  minuend.
- b  input  N  subtrahend.
- bi  input  1  borrow in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- d  output  N  difference, a - b - bi mod 2^N.
- bo  output  1  borrow out; 1 when unsigned a < b + bi.
- v  output  1  two's-complement overflow.

Behaviour:
- D = N/K digits. Digit counter cnt has width max(1, $clog2(D)).
- Reset (async assert, any state, including mid-operation): state=IDLE, cnt=0, carry=0, d=0, bo=0, v=0, out_valid=0, in_ready=1. Any in-flight operation is discarded.
- States are IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid, latch a and b, set carry=~bi and cnt=0, then go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each cycle: sum = a[cnt*K +: K] + ~b[cnt*K +: K] + carry.
  - Write d[cnt*K +: K] = sum[K-1:0]; carry = sum[K]; cnt++.
  - On the cycle processing cnt=D-1:
    - bo = ~sum[K].
    - v = (a[N-1]^b[N-1]) & (a[N-1]^d_new[N-1]).
    - Go to DONE.
- DONE:
  - out_valid=1, in_ready=0. d, bo and v are held stable.
  - On out_ready, go to IDLE. No new operand is accepted in that same cycle.
- Latency: out_valid rises exactly D clocks after the accepting edge. Throughput is 1 op per D+2 cycles minimum.
- out_valid held with out_ready=0: the result is held indefinitely and the upstream sees in_ready=0 (backpressure).
- in_valid is ignored outside IDLE. Operand inputs may change freely after acceptance, because the latched copies are used.
- D=1 (K=N): BUSY lasts one cycle and latency is 1.
- d, bo and v are undefined-free: they keep their last result in IDLE until overwritten digit by digit in BUSY. Consumers may only sample them when out_valid=1.

Decomposition:
- Package fixed_point_subtract_pkg holds:
  - the state enum typedef (IDLE, BUSY, DONE; 2-bit encoding);
  - the function computing the counter width from N and K.
- One combinational sub-module, subtract_digit: a K-bit a + ~b + cin, giving a K-bit sum and cout. It is instantiated once in the datapath.
- The FSM, counter and result registers stay in the top module.

Test Plan:
- N=32, K=8, a=0x00000005, b=0x00000003, bi=0: accepted edge T → out_valid at T+4, d=0x00000002, bo=0, v=0.
- a=0x00000000, b=0x00000001, bi=0: borrow ripples through all 4 digits → d=0xFFFFFFFF, bo=1, v=0.
- a=0x80000000, b=0x00000001, bi=1: d=0x7FFFFFFE, bo=0, v=1 (negative minus positive overflows).
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid → d, bo and v stable, in_ready=0.
  - in_valid pulsed during that window is ignored.
  - Then out_ready=1 for 1 cycle → IDLE next cycle, in_ready=1.
- Reset mid-operation:
  - Accept a=0xFFFFFFFF, b=0x12345678, then assert rst 2 cycles later → in_ready=1, out_valid=0, d=0, bo=0, v=0 immediately (async).
  - The next op a=0x10, b=0x01 returns d=0x0000000F after 4 cycles.
- Back-to-back random ops: 1000 random a, b, bi checked against a reference model of a - b - bi mod 2^32, with borrow and overflow compared. Also rerun with K=32 (latency 1) and K=1 (latency 32).
